// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between decode and alu_seq.
//   Request : in_valid, in_ready, opcode[2:0], a, b
//   Response: out_valid, out_ready, result_lo, result_hi,
//             flag_zero, flag_carry, flag_ovf, flag_err
// master = requester/consumer side, slave = the ALU.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             flag_zero;
    logic             flag_carry;
    logic             flag_ovf;
    logic             flag_err;

    modport master (
        output in_valid, opcode, a, b, out_ready,
        input  in_ready, out_valid, result_lo, result_hi,
        input  flag_zero, flag_carry, flag_ovf, flag_err
    );

    modport slave (
        input  in_valid, opcode, a, b, out_ready,
        output in_ready, out_valid, result_lo, result_hi,
        output flag_zero, flag_carry, flag_ovf, flag_err
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU. ADD/SUB/LOAD/STR/AND/XOR complete in one cycle;
// MUL is an iterative unsigned multiply retiring MUL_STEP multiplier bits per
// cycle and returning the full 2*WIDTH product.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - alu_seq_if.slave (request, response, flags)
// Optional: define ALU_SEQ_SIGNED_MUL_EN to turn opcode 011 into MULS
// (signed multiply); otherwise 011 is reserved and raises flag_err.
module alu_seq #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned MUL_STEP = 1
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    localparam int unsigned Steps = WIDTH / MUL_STEP;
    localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;

    localparam logic [2:0] OpAdd  = 3'b000;
    localparam logic [2:0] OpSub  = 3'b001;
    localparam logic [2:0] OpMul  = 3'b010;
    localparam logic [2:0] OpRsv  = 3'b011;
    localparam logic [2:0] OpLoad = 3'b100;
    localparam logic [2:0] OpStr  = 3'b101;
    localparam logic [2:0] OpAnd  = 3'b110;
    localparam logic [2:0] OpXor  = 3'b111;

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e             r_state, w_state_d;
    logic [2*WIDTH-1:0] r_mcand, r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [CntW-1:0]    r_cnt;
    logic               r_fin, r_neg;
    logic [WIDTH-1:0]   r_lo, r_hi;
    logic               r_z, r_c, r_o, r_e;

    logic               w_accept, w_is_mul, w_neg;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [WIDTH:0]     w_sum, w_diff;
    logic [WIDTH-1:0]   w_res;
    logic               w_zero, w_c, w_o, w_e;
    logic [2*WIDTH-1:0] w_pp, w_acc_step, w_prod;

    assign w_accept = bus.in_valid & bus.in_ready;

    // Single-cycle datapath, evaluated on the live bus and registered on accept.
    always_comb begin
        w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
        w_diff = {1'b0, bus.a} - {1'b0, bus.b};
        w_res  = '0;
        w_c    = 1'b0;
        w_o    = 1'b0;
        w_e    = 1'b0;
        case (bus.opcode)
            OpAdd: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_o   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OpSub: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];  // borrow == (a < b) unsigned
                w_o   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                        (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OpLoad, OpStr: w_res = w_sum[WIDTH-1:0];
            OpAnd:         w_res = bus.a & bus.b;
            OpXor:         w_res = bus.a ^ bus.b;
`ifndef ALU_SEQ_SIGNED_MUL_EN
            OpRsv:         w_e = 1'b1;
`endif
            default:       w_res = '0;
        endcase
    end
    assign w_zero = (w_res == '0);

    // Operand conditioning for the multiplier; signed operands become magnitudes.
    always_comb begin
        w_is_mul = (bus.opcode == OpMul);
        w_mag_a  = bus.a;
        w_mag_b  = bus.b;
        w_neg    = 1'b0;
`ifdef ALU_SEQ_SIGNED_MUL_EN
        if (bus.opcode == OpRsv) begin
            w_is_mul = 1'b1;
            w_mag_a  = bus.a[WIDTH-1] ? ('0 - bus.a) : bus.a;
            w_mag_b  = bus.b[WIDTH-1] ? ('0 - bus.b) : bus.b;
            w_neg    = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
        end
`endif
    end

    assign w_pp       = r_mcand * {{(2*WIDTH-MUL_STEP){1'b0}}, r_mplier[MUL_STEP-1:0]};
    assign w_acc_step = r_acc + w_pp;
    assign w_prod     = r_neg ? ('0 - r_acc) : r_acc;

    always_comb begin
        w_state_d     = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            StIdle: begin
                bus.in_ready = rst;
                if (w_accept) w_state_d = w_is_mul ? StMul : StDone;
            end
            StMul:  if (r_fin) w_state_d = StDone;
            StDone: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= StIdle;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_fin    <= 1'b0;
            r_neg    <= 1'b0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_o      <= 1'b0;
            r_e      <= 1'b0;
        end else begin
            r_state <= w_state_d;
            case (r_state)
                StIdle: if (w_accept) begin
                    if (w_is_mul) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_acc    <= '0;
                        r_cnt    <= CntW'(Steps - 1);
                        r_fin    <= 1'b0;
                        r_neg    <= w_neg;
                    end else begin
                        r_lo <= w_res;
                        r_hi <= '0;
                        r_z  <= w_zero;
                        r_c  <= w_c;
                        r_o  <= w_o;
                        r_e  <= w_e;
                    end
                end
                StMul: begin
                    // After the last step, one extra edge applies the sign fix
                    // and publishes the product.
                    if (r_fin) begin
                        r_lo <= w_prod[WIDTH-1:0];
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_z  <= (w_prod == '0);
                        r_c  <= 1'b0;
                        r_o  <= 1'b0;
                        r_e  <= 1'b0;
                    end else begin
                        r_acc    <= w_acc_step;
                        r_mcand  <= r_mcand << MUL_STEP;
                        r_mplier <= r_mplier >> MUL_STEP;
                        if (r_cnt == '0) r_fin <= 1'b1;
                        else             r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result_lo  = r_lo;
    assign bus.result_hi  = r_hi;
    assign bus.flag_zero  = r_z;
    assign bus.flag_carry = r_c;
    assign bus.flag_ovf   = r_o;
    assign bus.flag_err   = r_e;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a MUL_STEP=1 instance (index 0) and a MUL_STEP=4 instance
// (index 1), both WIDTH=16. Expected results come from a behavioural model and
// are queued at issue time, then popped when out_valid is seen.
module tb_alu_seq;
    typedef struct packed {
        logic [15:0] lo;
        logic [15:0] hi;
        logic        z, c, o, e;
    } res_t;

`ifdef ALU_SEQ_SIGNED_MUL_EN
    localparam int RsvLat = 17;
`else
    localparam int RsvLat = 0;
`endif

    logic        clk, rst_n;
    logic        t_valid [2];
    logic        t_oready[2];
    logic [2:0]  t_op    [2];
    logic [15:0] t_a     [2];
    logic [15:0] t_b     [2];
    logic        o_ready [2];
    logic        o_valid [2];
    logic [15:0] o_lo    [2];
    logic [15:0] o_hi    [2];
    logic        o_z[2], o_c[2], o_o[2], o_e[2];

    res_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    alu_seq_if #(.WIDTH(16)) bus0();
    alu_seq_if #(.WIDTH(16)) bus4();

    assign bus0.in_valid  = t_valid[0];
    assign bus0.out_ready = t_oready[0];
    assign bus0.opcode    = t_op[0];
    assign bus0.a         = t_a[0];
    assign bus0.b         = t_b[0];
    assign o_ready[0] = bus0.in_ready;
    assign o_valid[0] = bus0.out_valid;
    assign o_lo[0]    = bus0.result_lo;
    assign o_hi[0]    = bus0.result_hi;
    assign o_z[0]     = bus0.flag_zero;
    assign o_c[0]     = bus0.flag_carry;
    assign o_o[0]     = bus0.flag_ovf;
    assign o_e[0]     = bus0.flag_err;

    assign bus4.in_valid  = t_valid[1];
    assign bus4.out_ready = t_oready[1];
    assign bus4.opcode    = t_op[1];
    assign bus4.a         = t_a[1];
    assign bus4.b         = t_b[1];
    assign o_ready[1] = bus4.in_ready;
    assign o_valid[1] = bus4.out_valid;
    assign o_lo[1]    = bus4.result_lo;
    assign o_hi[1]    = bus4.result_hi;
    assign o_z[1]     = bus4.flag_zero;
    assign o_c[1]     = bus4.flag_carry;
    assign o_o[1]     = bus4.flag_ovf;
    assign o_e[1]     = bus4.flag_err;

    alu_seq #(.WIDTH(16), .MUL_STEP(1)) u_dut1 (.clk(clk), .rst(rst_n), .bus(bus0));
    alu_seq #(.WIDTH(16), .MUL_STEP(4)) u_dut4 (.clk(clk), .rst(rst_n), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic res_t model(input logic [2:0] op, input logic [15:0] a,
                                   input logic [15:0] b);
        res_t        r;
        int          sa, sbv, s;
        logic [16:0] u;
        logic [31:0] p;
        logic        is_mul;
        r      = '0;
        sa     = int'($signed(a));
        sbv    = int'($signed(b));
        is_mul = 1'b0;
        case (op)
            3'b000: begin
                u    = {1'b0, a} + {1'b0, b};
                r.lo = u[15:0];
                r.c  = u[16];
                s    = sa + sbv;
                r.o  = (s > 32767) || (s < -32768);
            end
            3'b001: begin
                r.lo = a - b;
                r.c  = (a < b);
                s    = sa - sbv;
                r.o  = (s > 32767) || (s < -32768);
            end
            3'b010: begin
                p      = {16'd0, a} * {16'd0, b};
                r.lo   = p[15:0];
                r.hi   = p[31:16];
                is_mul = 1'b1;
            end
            3'b011: begin
`ifdef ALU_SEQ_SIGNED_MUL_EN
                p      = 32'(sa * sbv);
                r.lo   = p[15:0];
                r.hi   = p[31:16];
                is_mul = 1'b1;
`else
                r.e = 1'b1;
`endif
            end
            3'b100, 3'b101: r.lo = a + b;
            3'b110:         r.lo = a & b;
            default:        r.lo = a ^ b;
        endcase
        r.z = is_mul ? ({r.hi, r.lo} == 32'd0) : (r.lo == 16'd0);
        return r;
    endfunction

    function automatic res_t observed(input int sel);
        return {o_lo[sel], o_hi[sel], o_z[sel], o_c[sel], o_o[sel], o_e[sel]};
    endfunction

    // Issue one op, queue its expected result, count edges after the accept edge
    // until out_valid is seen (capped at 60).
    task automatic drive_op(input int sel, input logic [2:0] op, input logic [15:0] a,
                            input logic [15:0] b, output int lat);
        int guard = 0;
        while (o_ready[sel] !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_checks++;
            $display("FAIL in_ready_timeout: dut %0d in_ready=%b required 1", sel, o_ready[sel]);
        end
        @(negedge clk);
        t_op[sel]    = op;
        t_a[sel]     = a;
        t_b[sel]     = b;
        t_valid[sel] = 1'b1;
        sb_q.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        t_valid[sel] = 1'b0;
        t_a[sel]     = ~a;  // later operand changes must not matter
        t_b[sel]     = ~b;
        lat = 0;
        while (o_valid[sel] !== 1'b1 && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out(input int sel);
        @(negedge clk);
        t_oready[sel] = 1'b1;
        @(posedge clk);
        #1;
        t_oready[sel] = 1'b0;
    endtask

    task automatic test_reset();
        res_t got;
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            t_valid[s] = 1'b0; t_oready[s] = 1'b0;
            t_op[s] = 3'b000; t_a[s] = 16'h0; t_b[s] = 16'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            got = observed(s);
            n_checks++;
            if (got !== '0 || o_valid[s] !== 1'b0 || o_ready[s] !== 1'b0)
                $display("FAIL reset_state: dut %0d res=%h valid=%b ready=%b required 0/0/0",
                         s, got, o_valid[s], o_ready[s]);
            else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            n_checks++;
            if (o_ready[s] !== 1'b1)
                $display("FAIL reset_release_ready: dut %0d in_ready=%b required 1", s, o_ready[s]);
            else n_pass++;
        end
    endtask

    task automatic test_alu();
        logic [2:0]  ops[10] = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b001,
                                 3'b100, 3'b101, 3'b110, 3'b111, 3'b000};
        logic [15:0] as [10] = '{16'd28, 16'd6, 16'h7FFF, 16'hFFFF, 16'h8000,
                                 16'h1000, 16'hFFFF, 16'hF0F0, 16'hA5A5, 16'h8000};
        logic [15:0] bs [10] = '{16'd22, 16'd8, 16'h0001, 16'h0001, 16'h0001,
                                 16'h0234, 16'h0002, 16'h3C3C, 16'hA5A5, 16'h8000};
        res_t exp, got;
        int   lat;
        for (int i = 0; i < 10; i++) begin
            drive_op(0, ops[i], as[i], bs[i], lat);
            n_checks++;
            if (lat !== 0) $display("FAIL alu_latency[%0d]: got %0d required 0", i, lat);
            else n_pass++;
            exp = sb_q.pop_front();
            got = observed(0);
            n_checks++;
            if (got !== exp) $display("FAIL alu_result[%0d]: got %h required %h", i, got, exp);
            else n_pass++;
            release_out(0);
        end
    endtask

    task automatic test_mul(input int sel, input int exp_lat);
        logic [15:0] as[5] = '{16'd255, 16'hFFFF, 16'd0,   16'hABCD, 16'd1};
        logic [15:0] bs[5] = '{16'd255, 16'hFFFF, 16'd123, 16'h1234, 16'h8001};
        res_t exp, got;
        int   lat;
        for (int i = 0; i < 5; i++) begin
            drive_op(sel, 3'b010, as[i], bs[i], lat);
            n_checks++;
            if (lat !== exp_lat)
                $display("FAIL mul_latency[%0d] dut %0d: got %0d required %0d", i, sel, lat, exp_lat);
            else n_pass++;
            exp = sb_q.pop_front();
            got = observed(sel);
            n_checks++;
            if (got !== exp)
                $display("FAIL mul_result[%0d] dut %0d: got %h required %h", i, sel, got, exp);
            else n_pass++;
            release_out(sel);
        end
    endtask

    task automatic test_back_pressure();
        res_t exp, got;
        int   lat;
        drive_op(0, 3'b010, 16'd123, 16'd456, lat);
        exp = sb_q.pop_front();
        got = observed(0);
        n_checks++;
        if (got !== exp || got.lo !== 16'd56088 || lat !== 17)
            $display("FAIL bp_result: got %h lat %0d required %h lat 17", got, lat, exp);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            t_op[0] = 3'b000; t_a[0] = 16'd1; t_b[0] = 16'd1; t_valid[0] = 1'b1;
            @(posedge clk);
            #1;
            n_checks++;
            if (o_valid[0] !== 1'b1 || o_lo[0] !== 16'd56088 || o_ready[0] !== 1'b0)
                $display("FAIL bp_hold[%0d]: valid=%b lo=%0d ready=%b required 1/56088/0",
                         i, o_valid[0], o_lo[0], o_ready[0]);
            else n_pass++;
        end
        @(negedge clk);
        t_valid[0]  = 1'b0;
        t_oready[0] = 1'b1;
        @(posedge clk);
        #1;
        t_oready[0] = 1'b0;
        n_checks++;
        if (o_valid[0] !== 1'b0 || o_ready[0] !== 1'b1)
            $display("FAIL bp_release: valid=%b ready=%b required 0/1", o_valid[0], o_ready[0]);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (o_valid[0] !== 1'b0)
            $display("FAIL bp_not_queued: valid=%b required 0", o_valid[0]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_mul();
        res_t exp, got;
        int   lat, stale;
        @(negedge clk);
        t_op[0] = 3'b010; t_a[0] = 16'hFFFF; t_b[0] = 16'hFFFF; t_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        t_valid[0] = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_valid[0] !== 1'b0 || o_lo[0] !== 16'h0 || o_hi[0] !== 16'h0 || o_ready[0] !== 1'b0)
            $display("FAIL midmul_reset: valid=%b lo=%h hi=%h ready=%b required 0/0/0/0",
                     o_valid[0], o_lo[0], o_hi[0], o_ready[0]);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (o_valid[0] === 1'b1) stale++;
        end
        n_checks++;
        if (stale !== 0) $display("FAIL midmul_stale: valid cycles %0d required 0", stale);
        else n_pass++;
        drive_op(0, 3'b000, 16'd1, 16'd2, lat);
        exp = sb_q.pop_front();
        got = observed(0);
        n_checks++;
        if (got !== exp || got.lo !== 16'd3 || lat !== 0)
            $display("FAIL midmul_next_add: got %h lat %0d required %h lat 0", got, lat, exp);
        else n_pass++;
        release_out(0);
    endtask

    task automatic test_reserved();
        logic [15:0] as[4] = '{16'd5, 16'hFFFF, 16'hFFFE, 16'h8000};
        logic [15:0] bs[4] = '{16'd7, 16'hFFFF, 16'd3,    16'h8000};
        res_t exp, got;
        int   lat;
        for (int i = 0; i < 4; i++) begin
            drive_op(0, 3'b011, as[i], bs[i], lat);
            exp = sb_q.pop_front();
            got = observed(0);
            n_checks++;
            if (got !== exp || lat !== RsvLat)
                $display("FAIL op011[%0d]: got %h lat %0d required %h lat %0d",
                         i, got, lat, exp, RsvLat);
            else n_pass++;
            release_out(0);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops[4] = '{3'b000, 3'b111, 3'b001, 3'b110};
        logic [15:0] as [4] = '{16'd100, 16'h1234, 16'd0, 16'hFF00};
        logic [15:0] bs [4] = '{16'd200, 16'h1234, 16'd1, 16'h0FF0};
        res_t exp, got;
        int   idx = 0, nres = 0, first = -1, last = -1;
        @(negedge clk);
        t_oready[0] = 1'b1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (o_ready[0] === 1'b1 && idx < 4) begin
                t_op[0] = ops[idx]; t_a[0] = as[idx]; t_b[0] = bs[idx];
                t_valid[0] = 1'b1;
                sb_q.push_back(model(ops[idx], as[idx], bs[idx]));
                idx++;
            end else if (o_ready[0] === 1'b1) begin
                t_valid[0] = 1'b0;
            end
            @(posedge clk);
            #1;
            if (o_valid[0] === 1'b1 && sb_q.size() > 0) begin
                exp = sb_q.pop_front();
                got = observed(0);
                n_checks++;
                if (got !== exp) $display("FAIL b2b_result[%0d]: got %h required %h", nres, got, exp);
                else n_pass++;
                if (first < 0) first = cyc;
                last = cyc;
                nres++;
            end
            @(negedge clk);
        end
        t_valid[0]  = 1'b0;
        t_oready[0] = 1'b0;
        n_checks++;
        if (nres !== 4 || (last - first) !== 6 || sb_q.size() !== 0)
            $display("FAIL b2b_throughput: results %0d span %0d left %0d required 4/6/0",
                     nres, last - first, sb_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mul(0, 17);
        test_mul(1, 5);
        test_back_pressure();
        test_reset_mid_mul();
        test_reserved();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
